// File: rtl/zebra_pkg.sv
// Shared types and default thresholds for the row stripe profiler and the zebra crossing detector.
package zebra_pkg;

    localparam int DEF_IMG_WIDTH         = 640;
    localparam int DEF_IMG_HEIGHT        = 480;
    localparam int DEF_PIXEL_W           = 8;
    localparam int DEF_EDGE_THRESHOLD    = 50;
    localparam int DEF_MIN_EDGES_PER_ROW = 80;
    localparam int DEF_MIN_RUN           = 4;

    localparam int SUM_IDX_W = $clog2(DEF_IMG_HEIGHT);
    localparam int SUM_EC_W  = $clog2(DEF_IMG_WIDTH + 1);
    localparam int SEG_W     = 8;

    typedef struct packed {
        logic [SUM_IDX_W-1:0] index;
        logic [SUM_EC_W-1:0]  edge_count;
        logic [SEG_W-1:0]     segment_count;
        logic                 is_stripe;
    } row_summary_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } prof_state_t;

    function automatic logic [SEG_W-1:0] sat_inc_seg(input logic [SEG_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/row_stripe_profiler_if.sv
// Row summary valid/ready channel from the profiler to its consumer.
interface row_stripe_profiler_if #(
    parameter int IDX_W = 9,
    parameter int EC_W  = 10
) ();
    import zebra_pkg::*;

    logic               row_valid;
    logic               row_ready;
    logic [IDX_W-1:0]   row_index;
    logic [EC_W-1:0]    row_edge_count;
    logic [SEG_W-1:0]   row_segment_count;
    logic               row_is_stripe;

    modport master (
        output row_valid, row_index, row_edge_count, row_segment_count, row_is_stripe,
        input  row_ready
    );

    modport slave (
        input  row_valid, row_index, row_edge_count, row_segment_count, row_is_stripe,
        output row_ready
    );

endinterface

// File: rtl/row_summary_fifo.sv
// Small in-order summary buffer; a push while full succeeds only when a pop happens in the same cycle.
module row_summary_fifo
    import zebra_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = row_summary_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    output logic full,
    input  logic pop,
    output T     dout,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == CNT_W'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= next_ptr(r_wr);
            end
            if (w_do_pop) begin
                r_rd <= next_ptr(r_rd);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/row_stripe_profiler.sv
// Thresholds streamed edge pixels and emits one {index, edge count, segments, stripe} summary per row.
// Define ROW_PROFILER_STATS_EN to count stripe rows per frame onto frame_stripe_rows.
module row_stripe_profiler
    import zebra_pkg::*;
#(
    parameter int IMG_WIDTH         = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT        = DEF_IMG_HEIGHT,
    parameter int W                 = DEF_PIXEL_W,
    parameter int EDGE_THRESHOLD    = DEF_EDGE_THRESHOLD,
    parameter int MIN_EDGES_PER_ROW = DEF_MIN_EDGES_PER_ROW,
    parameter int MIN_RUN           = DEF_MIN_RUN
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pixel_valid,
    input  logic [W-1:0]                      edge_pixel,
    input  logic                              sof,
    row_stripe_profiler_if.master             row_out,
    output logic                              frame_done,
    output logic                              overflow,
    output logic                              sync_error,
    output logic [$clog2(IMG_HEIGHT+1)-1:0]   frame_stripe_rows
);

    localparam int X_W   = $clog2(IMG_WIDTH);
    localparam int Y_W   = $clog2(IMG_HEIGHT);
    localparam int EC_W  = $clog2(IMG_WIDTH + 1);
    localparam int FS_W  = $clog2(IMG_HEIGHT + 1);
    localparam int RUN_W = $clog2(MIN_RUN + 1);

    typedef struct packed {
        logic [Y_W-1:0]   index;
        logic [EC_W-1:0]  edge_count;
        logic [SEG_W-1:0] segment_count;
        logic             is_stripe;
    } sum_t;

    prof_state_t      r_state;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [EC_W-1:0]  r_ec;
    logic [RUN_W-1:0] r_run;
    logic [SEG_W-1:0] r_seg;
    logic             r_push;
    sum_t             r_sum;
    logic             r_frame_done;
    logic             r_overflow;
    logic             r_sync_error;

    logic             w_accept;
    logic             w_restart;
    logic             w_desync;
    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    logic [EC_W-1:0]  w_ec_base;
    logic [RUN_W-1:0] w_run_base;
    logic [SEG_W-1:0] w_seg_base;
    logic             w_is_edge;
    logic [EC_W-1:0]  w_ec_next;
    logic [RUN_W-1:0] w_run_next;
    logic [SEG_W-1:0] w_seg_next;
    logic             w_row_end;
    logic             w_frame_end;
    logic             w_full;
    logic             w_empty;
    sum_t             w_head;

    // Any sof pixel is treated as (0,0) with fresh accumulators, whether it starts or resyncs a frame.
    assign w_accept   = pixel_valid && (r_state == STREAM || sof);
    assign w_restart  = pixel_valid && sof;
    assign w_desync   = w_restart && (r_state == STREAM) && (r_x != '0 || r_y != '0);
    assign w_x        = w_restart ? '0 : r_x;
    assign w_y        = w_restart ? '0 : r_y;
    assign w_ec_base  = w_restart ? '0 : r_ec;
    assign w_run_base = w_restart ? '0 : r_run;
    assign w_seg_base = w_restart ? '0 : r_seg;

    assign w_is_edge  = edge_pixel > W'(EDGE_THRESHOLD);
    assign w_ec_next  = w_ec_base + EC_W'(w_is_edge);
    assign w_run_next = !w_is_edge ? '0 :
                        (w_run_base == RUN_W'(MIN_RUN)) ? w_run_base : w_run_base + 1'b1;
    assign w_seg_next = (w_is_edge && w_run_base == RUN_W'(MIN_RUN - 1)) ?
                        sat_inc_seg(w_seg_base) : w_seg_base;
    assign w_row_end   = (w_x == X_W'(IMG_WIDTH - 1));
    assign w_frame_end = w_row_end && (w_y == Y_W'(IMG_HEIGHT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_ec         <= '0;
            r_run        <= '0;
            r_seg        <= '0;
            r_push       <= 1'b0;
            r_sum        <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_sync_error <= 1'b0;
        end else begin
            r_push       <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_desync) begin
                r_sync_error <= 1'b1;
            end
            if (r_push && w_full && !row_out.row_ready) begin
                r_overflow <= 1'b1;
            end
            if (w_accept) begin
                if (w_row_end) begin
                    r_push              <= 1'b1;
                    r_sum.index         <= w_y;
                    r_sum.edge_count    <= w_ec_next;
                    r_sum.segment_count <= w_seg_next;
                    r_sum.is_stripe     <= (w_ec_next >= EC_W'(MIN_EDGES_PER_ROW));
                    r_x                 <= '0;
                    r_ec                <= '0;
                    r_run               <= '0;
                    r_seg               <= '0;
                    if (w_frame_end) begin
                        r_y          <= '0;
                        r_state      <= IDLE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_y     <= w_y + 1'b1;
                        r_state <= STREAM;
                    end
                end else begin
                    r_x     <= w_x + 1'b1;
                    r_y     <= w_y;
                    r_ec    <= w_ec_next;
                    r_run   <= w_run_next;
                    r_seg   <= w_seg_next;
                    r_state <= STREAM;
                end
            end
        end
    end

    row_summary_fifo #(
        .DEPTH (2),
        .T     (sum_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_push),
        .din   (r_sum),
        .full  (w_full),
        .pop   (row_out.row_ready),
        .dout  (w_head),
        .empty (w_empty)
    );

    assign row_out.row_valid         = !w_empty;
    assign row_out.row_index         = w_head.index;
    assign row_out.row_edge_count    = w_head.edge_count;
    assign row_out.row_segment_count = w_head.segment_count;
    assign row_out.row_is_stripe     = w_head.is_stripe;

    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign sync_error = r_sync_error;

`ifdef ROW_PROFILER_STATS_EN
    logic [FS_W-1:0] r_stripe_cnt;
    logic [FS_W-1:0] r_frame_stripe_rows;
    logic [FS_W-1:0] w_stripe_cnt_next;

    // The last row's own flag is folded in on the frame_done cycle before the snapshot.
    assign w_stripe_cnt_next = r_stripe_cnt + FS_W'(r_sum.is_stripe);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stripe_cnt        <= '0;
            r_frame_stripe_rows <= '0;
        end else if (r_push) begin
            if (r_frame_done) begin
                r_frame_stripe_rows <= w_stripe_cnt_next;
                r_stripe_cnt        <= '0;
            end else begin
                r_stripe_cnt <= w_stripe_cnt_next;
            end
        end
    end

    assign frame_stripe_rows = r_frame_stripe_rows;
`else
    assign frame_stripe_rows = '0;
`endif

endmodule

// File: doc/row_stripe_profiler.md
# row_stripe_profiler

Streaming front-end stage between the convolution filter and the zebra crossing detector. It thresholds each edge-detected pixel as it arrives and accumulates per-row statistics: edge count, run-segment count, and a stripe flag. It delivers one summary per image row over a valid/ready handshake through a 2-entry buffer. This lets the detector work on compact row summaries instead of storing the whole frame.

## Interface
Parameters:
- IMG_WIDTH, 640, pixels per row
- IMG_HEIGHT, 480, rows per frame
- W, 8, pixel width
- EDGE_THRESHOLD, 50, pixel is edge when strictly greater
- MIN_EDGES_PER_ROW, 80, edge count at or above which row is a stripe
- MIN_RUN, 4, minimum consecutive edge pixels forming one segment

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- pixel_valid  in  1  edge_pixel valid this cycle
- edge_pixel  in  W  filtered pixel, raster order
- sof  in  1  start of frame, qualified by pixel_valid; marks pixel (0,0)
- row_valid  out  1  summary available
- row_ready  in  1  consumer accepts summary
- row_index  out  $clog2(IMG_HEIGHT)  row number of summary
- row_edge_count  out  $clog2(IMG_WIDTH+1)  edge pixels in row
- row_segment_count  out  8  qualifying runs in row, saturating at 255
- row_is_stripe  out  1  row_edge_count >= MIN_EDGES_PER_ROW
- frame_done  out  1  one-cycle pulse when the last row's summary is pushed
- overflow  out  1  sticky: a summary was dropped because the buffer was full
- sync_error  out  1  sticky: sof arrived with x≠0 or y≠0
- frame_stripe_rows  out  $clog2(IMG_HEIGHT+1)  stripe rows in last completed frame (see Configuration)

## Operation
- FSM states:
  - IDLE: waits for pixel_valid && sof; that pixel is processed as (0,0). Pixels without sof are ignored.
  - STREAM: accepts every pixel_valid cycle.
  - IDLE → STREAM on the first sof pixel. STREAM → IDLE after pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
- Counters: x counts 0..IMG_WIDTH-1 and wraps to 0, incrementing y. y wraps to 0 at frame end.
- Per pixel: is_edge = edge_pixel > EDGE_THRESHOLD (unsigned).
  - edge_count += is_edge.
  - run counter increments on edge pixels and saturates at MIN_RUN. It clears on a non-edge pixel.
  - A segment is counted once, at the pixel where the run reaches MIN_RUN. Maximal runs shorter than MIN_RUN add nothing.
  - segment_count saturates at 255.
- Row end (x = IMG_WIDTH-1 accepted): the summary {y, edge_count including this pixel, segment_count, stripe flag} is pushed next cycle. Accumulators clear for the next row. Runs never span rows.
- Buffer: 2-entry FIFO with in-order delivery.
  - Push when full with no pop in the same cycle: summary dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed.
- sof in STREAM with (x,y) ≠ (0,0): partial row discarded, sync_error set, pixel processed as (0,0). Already-buffered summaries are kept.
- frame_done pulses in the push cycle of the row with index IMG_HEIGHT-1, whether or not that push was dropped.
- overflow and sync_error clear only on rst.

## Timing
- Reset values: all outputs 0. FSM in IDLE, FIFO empty, counters 0.
- rst is asynchronous: outputs go to 0 without waiting for a clock edge. A row in progress is lost.
- Latency: with the FIFO empty, row_valid rises on the second rising edge after the last pixel of the row is sampled, i.e. it is visible in the cycle after the push.
- Handshake:
  - A transfer occurs on an edge where row_valid && row_ready.
  - While row_valid && !row_ready, all row_* outputs hold stable.
  - row_valid never drops without a transfer.
  - Back-to-back transfers run at 1 per cycle.
- Throughput: one pixel per clock, with no pixel stall. Backpressure only affects summaries.

## Configuration
- ROW_PROFILER_STATS_EN defined:
  - A counter of stripe summaries pushed in the current frame is maintained.
  - On the frame_done cycle it is copied into frame_stripe_rows and then cleared. Counting includes the last row's own stripe flag.
- Undefined: the counter logic is absent and frame_stripe_rows is tied to 0. The port list is unchanged.

## Structure
- Package zebra_pkg:
  - row_summary_t packed struct {index, edge_count, segment_count, is_stripe}
  - profiler state enum {IDLE, STREAM}
  - default threshold constants, shared with zebra_crossing_detector
- Sub-module row_summary_fifo: parameterised depth (2 here), carries row_summary_t, exposes push/full/pop/empty. It is instantiated once.

## Test plan
Params for the bench: IMG_WIDTH=16, IMG_HEIGHT=4, MIN_EDGES_PER_ROW=6, MIN_RUN=2, EDGE_THRESHOLD=50.
- All-255 row after sof, row_ready=1 → one summary: index 0, edge 16, seg 1, stripe 1. row_valid seen 2 edges after pixel 15.
- Row pattern {255,255,255,0}×4 → edge 12, seg 4, stripe 1. Row pattern {255,0}×8 → edge 8, seg 0, stripe 1. All-50 row → edge 0, seg 0, stripe 0.
- row_ready=0 for 3 full rows → row_valid held on row 0, third summary dropped, overflow=1. Raising row_ready then yields rows 0, 1 on consecutive cycles, then row_valid=0.
- sof re-asserted at x=7 of row 1 → sync_error=1, no summary for the partial row, next summary has index 0.
- rst pulsed mid-row 2 with 1 summary buffered → row_valid, flags, and frame_stripe_rows are 0 immediately. The block ignores pixels until the next sof.
- Full 4-row frame with rows 0, 2 stripe → frame_done pulses once with the row-3 push. frame_stripe_rows=2 with ROW_PROFILER_STATS_EN defined, 0 without.
